// File: rtl/axppa_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axppa_error_monitor
// Desc     : Windowed error-distance statistics for the approximate prefix
//            adder. Define AXPPA_BIAS_EN to add the signed ed_bias output.
// Revision : 1.0 - initial release
// ============================================================================
module axppa_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 1024,
    parameter int CNT_W       = 16,
    parameter int ACC_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH:0]   Sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] ed_sum,
    output logic [WIDTH:0]   ed_max,
    output logic [CNT_W-1:0] sample_count
`ifdef AXPPA_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] ed_bias
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_NUM_SAMPLES = CNT_W'(NUM_SAMPLES);

    state_t           r_state;
    logic             r_done;
    logic [CNT_W-1:0] r_accepted;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_sample_count;
    logic [ACC_W-1:0] r_ed_sum;
    logic [WIDTH:0]   r_ed_max;
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [WIDTH:0]   r_s1_exact;
    logic [WIDTH:0]   r_s1_sum;
    logic [WIDTH:0]   r_s2_ed;

    logic             w_hs;
    logic             w_pipe_empty;
    logic [WIDTH:0]   w_ed;
    logic [ACC_W:0]   w_sum_ext;
    logic [ACC_W-1:0] w_sum_sat;

    assign in_ready     = (r_state == ST_RUN) && (r_accepted < c_NUM_SAMPLES) && !start;
    assign w_hs         = in_valid && in_ready;
    assign w_pipe_empty = !r_s1_valid && !r_s2_valid;

    assign w_ed      = (r_s1_sum >= r_s1_exact) ? (r_s1_sum - r_s1_exact)
                                                : (r_s1_exact - r_s1_sum);
    // One extra bit catches the carry so the sum can pin instead of wrapping.
    assign w_sum_ext = {1'b0, r_ed_sum} + (ACC_W+1)'(r_s2_ed);
    assign w_sum_sat = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_done         <= 1'b0;
            r_accepted     <= '0;
            r_err_count    <= '0;
            r_sample_count <= '0;
            r_ed_sum       <= '0;
            r_ed_max       <= '0;
            r_s1_valid     <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_s1_exact     <= '0;
            r_s1_sum       <= '0;
            r_s2_ed        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!start && (r_accepted == c_NUM_SAMPLES) && w_pipe_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A start in any state opens a fresh window and drops in-flight samples.
            if (start) begin
                r_accepted     <= '0;
                r_err_count    <= '0;
                r_sample_count <= '0;
                r_ed_sum       <= '0;
                r_ed_max       <= '0;
                r_s1_valid     <= 1'b0;
                r_s2_valid     <= 1'b0;
            end else begin
                r_s1_valid <= w_hs;
                r_s2_valid <= r_s1_valid;
                if (w_hs) begin
                    r_accepted <= r_accepted + 1'b1;
                    r_s1_exact <= {1'b0, A} + {1'b0, B};
                    r_s1_sum   <= Sum;
                end
                if (r_s1_valid) r_s2_ed <= w_ed;
                if (r_s2_valid) begin
                    r_sample_count <= r_sample_count + 1'b1;
                    r_err_count    <= r_err_count + CNT_W'(r_s2_ed != '0);
                    r_ed_sum       <= w_sum_sat;
                    if (r_s2_ed > r_ed_max) r_ed_max <= r_s2_ed;
                end
            end
        end
    end

    assign busy         = (r_state == ST_RUN);
    assign done         = r_done;
    assign err_count    = r_err_count;
    assign ed_sum       = r_ed_sum;
    assign ed_max       = r_ed_max;
    assign sample_count = r_sample_count;

`ifdef AXPPA_BIAS_EN
    localparam logic signed [ACC_W:0] c_BIAS_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_BIAS_MIN = -c_BIAS_MAX;

    logic signed [ACC_W-1:0] r_ed_bias;
    logic signed [WIDTH+1:0] r_s2_diff;
    logic signed [WIDTH+1:0] w_diff;
    logic signed [ACC_W:0]   w_bias_ext;
    logic signed [ACC_W:0]   w_bias_sat;

    assign w_diff     = $signed({1'b0, r_s1_sum}) - $signed({1'b0, r_s1_exact});
    assign w_bias_ext = $signed({r_ed_bias[ACC_W-1], r_ed_bias}) + (ACC_W+1)'(r_s2_diff);
    assign w_bias_sat = (w_bias_ext > c_BIAS_MAX) ? c_BIAS_MAX :
                        (w_bias_ext < c_BIAS_MIN) ? c_BIAS_MIN : w_bias_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ed_bias <= '0;
            r_s2_diff <= '0;
        end else if (start) begin
            r_ed_bias <= '0;
        end else begin
            if (r_s1_valid) r_s2_diff <= w_diff;
            if (r_s2_valid) r_ed_bias <= w_bias_sat[ACC_W-1:0];
        end
    end

    assign ed_bias = r_ed_bias;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axppa_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axppa_error_monitor
// Desc     : Scoreboard bench for axppa_error_monitor (NUM_SAMPLES=4, ACC_W=17).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axppa_error_monitor;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int ACC_W = 17;
    localparam longint SUM_SAT  = (64'sd1 << ACC_W) - 1;
    localparam longint BIAS_SAT = (64'sd1 << (ACC_W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [WIDTH:0]   Sum = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH:0]   ed_max;
    logic [CNT_W-1:0] sample_count;
`ifdef AXPPA_BIAS_EN
    logic signed [ACC_W-1:0] ed_bias;
`endif

    axppa_error_monitor #(
        .WIDTH(WIDTH), .NUM_SAMPLES(N), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sum(Sum), .busy(busy), .done(done),
        .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max),
        .sample_count(sample_count)
`ifdef AXPPA_BIAS_EN
        , .ed_bias(ed_bias)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint cnt;
        longint bias;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     done_seen = 0;
    int     win_done0 = 0;
    logic   prev_done = 1'b0;

    // Reference model: window statistics straight from the arithmetic definition.
    bit     m_run = 0;
    int     m_acc = 0;
    longint m_err, m_sum, m_max, m_cnt, m_bias;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_err = 0; m_sum = 0; m_max = 0; m_cnt = 0; m_bias = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH:0] s);
        longint diff, ed;
        exp_t   e;
        diff = longint'(s) - (longint'(a) + longint'(b));
        ed   = (diff < 0) ? -diff : diff;
        m_acc++;
        m_cnt++;
        if (ed != 0) m_err++;
        m_sum  = (m_sum + ed > SUM_SAT) ? SUM_SAT : m_sum + ed;
        if (ed > m_max) m_max = ed;
        m_bias = m_bias + diff;
        if (m_bias > BIAS_SAT)  m_bias = BIAS_SAT;
        if (m_bias < -BIAS_SAT) m_bias = -BIAS_SAT;
        if (m_acc == N) begin
            e.err = m_err; e.sum = m_sum; e.mx = m_max; e.cnt = m_cnt; e.bias = m_bias;
            sb_q.push_back(e);
        end
    endtask

    task automatic gen(input int kind, output logic [WIDTH-1:0] a,
                       output logic [WIDTH-1:0] b, output logic [WIDTH:0] s);
        logic [WIDTH:0] ex;
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        ex = {1'b0, a} + {1'b0, b};
        case (kind)
            0: s = ex;
            1: s = ex + (WIDTH+1)'($urandom_range(0, 8)) - (WIDTH+1)'(4);
            2: s = (WIDTH+1)'($urandom);
            default: begin a = '1; b = '1; s = '0; end
        endcase
    endtask

    // One clock of stimulus: drive on the falling edge, handshake on the rising edge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH:0] s);
        bit exp_rdy;
        @(negedge clk);
        start = 1'b0; in_valid = v; A = a; B = b; Sum = s;
        #1;
        exp_rdy = m_run && (m_acc < N);
        check("in_ready", longint'(in_ready), longint'(exp_rdy));
        if (v && exp_rdy) model_accept(a, b, s);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1;
        #1;
        check("in_ready_during_start", longint'(in_ready), 0);
        m_run = 1;
        model_clear();
        win_done0 = done_seen;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        check("busy_after_start", longint'(busy), 1);
    endtask

    task automatic wait_done();
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   s;
        for (int i = 0; i < 30 && done_seen == win_done0; i++) begin
            gen(2, a, b, s);
            cycle(1'b1, a, b, s);
        end
        if (done_seen == win_done0) check("done_timeout", 0, 1);
    endtask

    task automatic run_window(input int kind, input bit rand_valid);
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   s;
        do_start();
        while (m_acc < N) begin
            gen((kind < 0) ? int'($urandom_range(0, 3)) : kind, a, b, s);
            cycle(rand_valid ? bit'($urandom_range(0, 1)) : 1'b1, a, b, s);
        end
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_err_count"}, longint'(err_count), 0);
        check({tag, "_ed_sum"}, longint'(ed_sum), 0);
        check({tag, "_ed_max"}, longint'(ed_max), 0);
        check({tag, "_sample_count"}, longint'(sample_count), 0);
`ifdef AXPPA_BIAS_EN
        check({tag, "_ed_bias"}, longint'(ed_bias), 0);
`endif
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_seen++;
            check("done_single_pulse", longint'(prev_done), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("err_count", longint'(err_count), e.err);
                check("ed_sum", longint'(ed_sum), e.sum);
                check("ed_max", longint'(ed_max), e.mx);
                check("sample_count", longint'(sample_count), e.cnt);
                check("busy_at_done", longint'(busy), 0);
`ifdef AXPPA_BIAS_EN
                check("ed_bias", longint'(ed_bias), e.bias);
`endif
            end
        end
        prev_done <= done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   s;
        model_clear();
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        idle(2);

        // Four exact samples.
        do_start();
        for (int i = 0; i < N; i++) cycle(1'b1, 16'h0010, 16'h0020, 17'h00030);
        wait_done();
        // Outputs must hold in DONE.
        idle(3);
        check("hold_sample_count", longint'(sample_count), N);
        check("hold_ed_sum", longint'(ed_sum), 0);

        // One sample with ED=4 plus three exact.
        do_start();
        cycle(1'b1, 16'h003F, 16'h0001, 17'h0003C);
        for (int i = 1; i < N; i++) cycle(1'b1, 16'h1234, 16'h0101, 17'h01335);
        wait_done();

        // Largest ED repeatedly: ed_sum saturates.
        run_window(3, 1'b0);

        // Restart after two samples: in-flight work is discarded.
        do_start();
        cycle(1'b1, 16'h003F, 16'h0001, 17'h0003C);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 17'h00000);
        do_start();
        for (int i = 0; i < N; i++) cycle(1'b1, 16'h0100, 16'h0001, 17'h00100);
        wait_done();

        // Randomized windows with random in_valid gaps.
        for (int w = 0; w < 12; w++) run_window(-1, 1'b1);

        // Asynchronous reset mid-window after two Sum = exact-3 samples.
        do_start();
        cycle(1'b1, 16'h0100, 16'h0023, 17'h00120);
        cycle(1'b1, 16'h0100, 16'h0023, 17'h00120);
        idle(4);
        check("pre_reset_sample_count", longint'(sample_count), 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        m_run = 0;
        model_clear();
        @(negedge clk) rst = 1'b0;
        idle(2);
        do_start();
        cycle(1'b1, 16'h0100, 16'h0023, 17'h00120);
        cycle(1'b1, 16'h0100, 16'h0023, 17'h00120);
        idle(4);
        check("rerun_sample_count", longint'(sample_count), 2);
        check("rerun_err_count", longint'(err_count), 2);
        check("rerun_ed_sum", longint'(ed_sum), 6);
        check("rerun_ed_max", longint'(ed_max), 3);
`ifdef AXPPA_BIAS_EN
        check("rerun_ed_bias", longint'(ed_bias), -6);
`endif
        for (int i = 2; i < N; i++) begin
            gen(1, a, b, s);
            cycle(1'b1, a, b, s);
        end
        wait_done();

        idle(3);
        check("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
